// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (icache/dcache) arbiter onto a single RAM port.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int LAT_MAX = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        arb_err,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] igrant_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;
  localparam logic [4:0] LMAX   = 5'(LAT_MAX);

  logic [1:0] r_state;
  logic [4:0] r_wdog;
  logic       r_last_i;
  logic       r_err;

  logic [1:0] w_next;
  logic       w_dreq;
  logic       w_ireq;
  logic       w_access;
  logic       w_stop;
  logic       w_done;
  logic       w_abort;

  assign w_dreq   = dREN | dWEN;
  assign w_ireq   = iREN;
  assign w_access = (ramstate == ACCESS);
  assign w_stop   = (ramstate == ERROR) || (r_wdog >= LMAX);
  assign arb_err  = r_err;

  // Next state, RAM muxing and master handshake for the current state
  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'h0;
    dload    = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_dreq && (!w_ireq || r_last_i))
          w_next = DGRANT;
        else if (w_ireq)
          w_next = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_dreq) begin
          w_next = IDLE;
        end else if (w_access) begin
          dwait  = 1'b0;
          dload  = ramload;
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_stop) begin
          ramREN  = 1'b0;
          ramWEN  = 1'b0;
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!w_ireq) begin
          w_next = IDLE;
        end else if (w_access) begin
          iwait  = 1'b0;
          iload  = ramload;
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_stop) begin
          ramREN  = 1'b0;
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, watchdog, fairness flag and sticky abort flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_wdog   <= 5'd0;
      r_last_i <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE)
        r_wdog <= 5'd0;
      else if (!w_access && r_wdog != 5'h1f)
        r_wdog <= r_wdog + 5'd1;
      if (w_done)
        r_last_i <= (r_state == IGRANT);
      if (w_abort)
        r_err <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_dcnt;
  logic [31:0] r_icnt;

  // Completed-grant counters, wrapping modulo 2^32
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dcnt <= 32'h0;
      r_icnt <= 32'h0;
    end else if (w_done) begin
      if (r_state == DGRANT)
        r_dcnt <= r_dcnt + 32'd1;
      else
        r_icnt <= r_icnt + 32'd1;
    end
  end

  assign dgrant_cnt = r_dcnt;
  assign igrant_cnt = r_icnt;
`else
  assign dgrant_cnt = 32'h0;
  assign igrant_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed per-cycle vectors plus hand sequences for
// withdrawal, watchdog timeout, ERROR abort and asynchronous reset.
module tb_bus_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] dgrant_cnt, igrant_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter #(.LAT_MAX(15)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .arb_err(arb_err), .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds, rl;
    ramstate_t   rs;
    logic [132:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [132:0] ex(
    input logic iw, dwt, input logic [31:0] il, dl,
    input logic ren, wen, input logic [31:0] ad, st, input logic er);
    return {iw, dwt, il, dl, ren, wen, ad, st, er};
  endfunction

  function automatic logic [132:0] act();
    return {iwait, dwait, iload, dload, ramREN, ramWEN,
            ramaddr, ramstore, arb_err};
  endfunction

  task automatic add(input string nm, input logic ir, dr, dw,
    input logic [31:0] ia, da, ds, rl, input ramstate_t rs,
    input logic [132:0] e);
    vec_t v;
    v.nm = nm; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl;
    v.rs = rs; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [132:0] a,
    input logic [132:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE;
  endtask

  logic [132:0] IDL;
  logic [31:0]  exp_d, exp_i;
  int           nren;
  logic         lowseen;

  initial begin
    IDL = ex(1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_STATS_EN
    exp_d = 32'd4; exp_i = 32'd2;
`else
    exp_d = 32'd0; exp_i = 32'd0;
`endif
    // tie: D,I,D,I from reset
    add("tie0", 1,1,0, 'h100,'h200,0,'hA0, ACCESS, IDL);
    add("tie1", 1,1,0, 'h100,'h200,0,'hA1, ACCESS,
        ex(1,0,0,'hA1,1,0,'h200,0,0));
    add("tie2", 1,1,0, 'h100,'h200,0,'hA2, ACCESS, IDL);
    add("tie3", 1,1,0, 'h100,'h200,0,'hA3, ACCESS,
        ex(0,1,'hA3,0,1,0,'h100,0,0));
    add("tie4", 1,1,0, 'h100,'h200,0,'hA4, ACCESS, IDL);
    add("tie5", 1,1,0, 'h100,'h200,0,'hA5, ACCESS,
        ex(1,0,0,'hA5,1,0,'h200,0,0));
    add("tie6", 1,1,0, 'h100,'h200,0,'hA6, ACCESS, IDL);
    add("tie7", 1,1,0, 'h100,'h200,0,'hA7, ACCESS,
        ex(0,1,'hA7,0,1,0,'h100,0,0));
    add("idle8", 0,0,0, 0,0,0,0, FREE, IDL);
    // dcache read with 2 BUSY cycles
    add("rd_a", 0,1,0, 0,'h40,0,'h11111111, BUSY, IDL);
    add("rd_b", 0,1,0, 0,'h40,0,'h11111111, BUSY,
        ex(1,1,0,0,1,0,'h40,0,0));
    add("rd_c", 0,1,0, 0,'h40,0,'h22222222, BUSY,
        ex(1,1,0,0,1,0,'h40,0,0));
    add("rd_d", 0,1,0, 0,'h40,0,'hDEADBEEF, ACCESS,
        ex(1,0,0,'hDEADBEEF,1,0,'h40,0,0));
    add("rd_e", 0,0,0, 0,0,0,'h33, FREE, IDL);
    // dcache write, write beats read
    add("wr_a", 0,1,1, 0,'h3100,'h12345678,0, FREE, IDL);
    add("wr_b", 0,1,1, 0,'h3100,'h12345678,'h44, BUSY,
        ex(1,1,0,0,0,1,'h3100,'h12345678,0));
    add("wr_c", 0,1,1, 0,'h3100,'h12345678,'hCAFEF00D, ACCESS,
        ex(1,0,0,'hCAFEF00D,0,1,'h3100,'h12345678,0));
    add("wr_d", 0,0,0, 0,0,0,0, FREE, IDL);

    idle_in();
    nRST = 0;
    #3;
    chk("reset_state", act(), IDL);
    @(negedge CLK);
    nRST = 1;

    foreach (tv[k]) begin
      @(negedge CLK);
      iREN = tv[k].ir; dREN = tv[k].dr; dWEN = tv[k].dw;
      iaddr = tv[k].ia; daddr = tv[k].da; dstore = tv[k].ds;
      ramload = tv[k].rl; ramstate = tv[k].rs;
      #1;
      chk(tv[k].nm, act(), tv[k].exp);
    end

    @(negedge CLK);
    idle_in();
    #1;
    chk("cnt_after_tbl", 133'({dgrant_cnt, igrant_cnt}),
        133'({exp_d, exp_i}));

    // withdrawal before ACCESS
    @(negedge CLK);
    dREN = 1; daddr = 32'h80; ramstate = BUSY;
    @(negedge CLK);
    #1;
    chk("wd_grant", 133'({ramREN, ramaddr}), 133'({1'b1, 32'h80}));
    dREN = 0; ramstate = ACCESS; ramload = 32'h77;
    #1;
    chk("wd_nocomp", 133'({dwait, dload}), 133'({1'b1, 32'h0}));
    @(negedge CLK);
    dREN = 1; daddr = 32'h90; ramstate = BUSY;
    #1;
    chk("wd_idle", 133'({ramREN, ramaddr, dgrant_cnt}),
        133'({1'b0, 32'h0, exp_d}));
    @(negedge CLK);
    idle_in();

    // icache watchdog timeout
    @(negedge CLK);
    iREN = 1; iaddr = 32'h500; ramstate = BUSY;
    nren = 0; lowseen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!iwait) lowseen = 1;
      if (ramREN) nren++;
      if (arb_err) break;
      @(negedge CLK);
    end
    iREN = 0;
    chk("wdog_cycles", 133'(nren), 133'(15));
    chk("wdog_iwait", 133'(lowseen), 133'(0));
    chk("wdog_err", 133'({arb_err, ramREN, ramaddr}),
        133'({1'b1, 1'b0, 32'h0}));
    @(negedge CLK);
    idle_in();

    // async reset mid-DGRANT
    @(negedge CLK);
    dREN = 1; daddr = 32'h40; ramstate = BUSY;
    @(negedge CLK);
    #1;
    chk("rst_pre", 133'({ramREN, ramaddr}), 133'({1'b1, 32'h40}));
    #1;
    nRST = 0;
    #1;
    chk("rst_async", act(), IDL);
    chk("rst_cnt", 133'({dgrant_cnt, igrant_cnt}), 133'(0));
    @(negedge CLK);
    idle_in();
    nRST = 1;

    // ERROR aborts in the same cycle
    @(negedge CLK);
    dREN = 1; daddr = 32'h44;
    @(negedge CLK);
    ramstate = ERROR;
    #1;
    chk("err_cycle", 133'({ramREN, dwait, arb_err}), 133'(3'b010));
    @(negedge CLK);
    idle_in();
    #1;
    chk("err_after", 133'({arb_err, ramREN, dgrant_cnt}),
        133'({1'b1, 1'b0, 32'h0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
